ifq_fifo: RTL and testbench

Instruction fetch queue storage. It sits directly downstream of the fetch-queue controller and consumes that controller's `push_fifo`, `pop_fifo` and `bypass` strobes. It latches a 4-instruction cache line, splits it into 32-bit words (one word per push), and buffers those words in a circular FIFO for the decode stage. It returns `fifo_empty` and `fifo_full` to the controller, and supports a same-cycle bypass and a branch flush.

---
 rtl/ifq_fifo.sv | 128 ++++++++++++
 tb/tb_ifq_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ifq_fifo.sv
// Instruction fetch queue storage: latches a cache line, splits it into
// words and buffers them in a circular FIFO with bypass and flush.
module ifq_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH*WORDS-1:0]     line_in,
  input  logic                       line_valid,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       bypass,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic                       fifo_empty,
  output logic                       fifo_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] LAST = 2'(WORDS - 1);

  logic [WIDTH*WORDS-1:0] line_q, line_d;
  logic [1:0]             word_ptr_q, word_ptr_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic [WIDTH-1:0]       mem_q [DEPTH];

  logic             bypass_act;
  logic             consume;
  logic             pop_acc;
  logic             push_acc;
  logic             mem_we;
  logic [WIDTH-1:0] push_word;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign count      = count_q;
  assign overflow   = ovf_q;

  // Bypass only forwards into an empty queue, so ordering is preserved.
  assign bypass_act = bypass & line_valid & fifo_empty;
  assign consume    = bypass_act & pop;
  assign pop_acc    = pop & ~fifo_empty;
  assign push_acc   = push & ~consume & (~fifo_full | pop_acc);
  assign mem_we     = push_acc & ~flush;

  assign push_word = line_valid ? line_in[WIDTH-1:0]
                   : line_q[int'(word_ptr_q)*WIDTH +: WIDTH];

  assign dout       = bypass_act ? line_in[WIDTH-1:0] : mem_q[rd_ptr_q];
  assign dout_valid = bypass_act | ~fifo_empty;

  always_comb begin
    line_d     = line_q;
    word_ptr_d = word_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    if (flush) begin
      word_ptr_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      ovf_d      = 1'b0;
    end else begin
      if (line_valid) begin
        line_d     = line_in;
        word_ptr_d = '0;
      end
      if (consume) begin
        word_ptr_d = 2'd1;
      end else begin
        // A dropped push still consumes its line word.
        if (push) begin
          if (line_valid)
            word_ptr_d = 2'd1;
          else if (word_ptr_q == LAST)
            word_ptr_d = '0;
          else
            word_ptr_d = word_ptr_q + 2'd1;
          if (!push_acc)
            ovf_d = 1'b1;
        end
        if (push_acc)
          wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_acc)
          rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_acc && !pop_acc)
          count_d = count_q + CW'(1);
        else if (pop_acc && !push_acc)
          count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q     <= '0;
      word_ptr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      line_q     <= line_d;
      word_ptr_q <= word_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem_q[wr_ptr_q] <= push_word;
  end

endmodule

// File: tb/tb_ifq_fifo.sv
// Directed bench for ifq_fifo with a queue scoreboard of expected words.
module tb_ifq_fifo;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] line_in = '0;
  logic         line_valid = 1'b0;
  logic         push = 1'b0;
  logic         pop = 1'b0;
  logic         bypass = 1'b0;
  logic         flush = 1'b0;
  logic [31:0]  dout;
  logic         dout_valid;
  logic         fifo_empty;
  logic         fifo_full;
  logic [3:0]   count;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  logic [31:0]  sq[$];
  int           mcount = 0;
  int           mwp = 0;
  logic [127:0] mline = '0;
  logic         mover = 1'b0;

  always #5 clk = ~clk;

  ifq_fifo #(.DEPTH(8), .WIDTH(32), .WORDS(4)) dut (
    .clk(clk), .reset(reset), .line_in(line_in),
    .line_valid(line_valid), .push(push), .pop(pop),
    .bypass(bypass), .flush(flush), .dout(dout),
    .dout_valid(dout_valid), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .count(count), .overflow(overflow)
  );

  function automatic logic [127:0] mk(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic lv, input logic [127:0] li,
                     input logic pu, input logic po,
                     input logic by, input logic fl);
    logic        bact;
    logic        popa;
    logic        acc;
    logic [31:0] w;
    @(negedge clk);
    line_valid = lv;
    line_in    = li;
    push       = pu;
    pop        = po;
    bypass     = by;
    flush      = fl;
    #1;
    bact = by && lv && (mcount == 0);
    chk("count", 32'(count), 32'(mcount));
    chk("empty", 32'(fifo_empty), 32'(mcount == 0));
    chk("full", 32'(fifo_full), 32'(mcount == 8));
    chk("overflow", 32'(overflow), 32'(mover));
    chk("dout_valid", 32'(dout_valid), 32'(bact || mcount > 0));
    if (bact)
      chk("bypass_dout", dout, li[31:0]);
    else if (mcount > 0)
      chk("dout", dout, sq[0]);
    w   = lv ? li[31:0] : mline[mwp*32 +: 32];
    acc = 1'b0;
    if (fl) begin
      sq.delete();
      mwp   = 0;
      mover = 1'b0;
    end else begin
      popa = po && (sq.size() > 0);
      if (bact && po) begin
        mwp = 1;
      end else begin
        if (pu) begin
          if (sq.size() < 8 || popa) acc = 1'b1;
          else mover = 1'b1;
          mwp = lv ? 1 : (mwp + 1) % 4;
        end else if (lv) begin
          mwp = 0;
        end
        if (popa) void'(sq.pop_front());
        if (acc) sq.push_back(w);
      end
      if (lv) mline = li;
    end
    mcount = sq.size();
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    line_valid = 1'b0;
    line_in    = '0;
    push       = 1'b0;
    pop        = 1'b0;
    bypass     = 1'b0;
    flush      = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_dvalid", 32'(dout_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sq.delete();
    mcount = 0;
    mwp    = 0;
    mline  = '0;
    mover  = 1'b0;
  endtask

  task automatic fill8(input logic [31:0] b0, input logic [31:0] b1);
    cyc(1'b1, mk(b0), 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, mk(b1), 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    do_reset();

    // line A..D, four pushes plus one more to show the word pointer wrap
    cyc(1'b1, mk(32'h1000_0000), 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

    // overflow: ninth push dropped
    fill8(32'h2000_0000, 32'h3000_0000);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (8) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // full with simultaneous push and pop
    fill8(32'h4000_0000, 32'h5000_0000);
    cyc(1'b1, mk(32'h6000_0000), 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (8) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // bypass consume, then the next push takes word 1
    cyc(1'b1, {32'hCC, 32'hBB, 32'hAA, 32'h13}, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // empty push+pop without bypass, then bypass with push only
    cyc(1'b1, mk(32'h6800_0000), 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, mk(32'h6900_0000), 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

    // five queued, overflow set, then flush with push
    fill8(32'h7000_0000, 32'h7100_0000);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // pop on empty
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset mid-burst, then operation resumes from empty
    cyc(1'b1, mk(32'h8000_0000), 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    cyc(1'b1, mk(32'h9000_0000), 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
